// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for an 8-bit loadable up/down counter.
// A single-cycle run command loads the counter with start_val.
// The controller then steps the counter toward end_val.
// pause holds the counter, and abort ends the run without a done pulse.
// All outputs are registered. The counter itself updates on the falling edge,
// so a mode issued at rising edge k shows up on cnt_in at rising edge k+1.
module counter_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] end_val,
   input  logic             pause,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [1:0]       m,
   output logic [WIDTH-1:0] p,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   steps,
   output logic             wrapped
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] M_HOLD = 2'd0;
   localparam logic [1:0] M_INC  = 2'd1;
   localparam logic [1:0] M_DEC  = 2'd2;
   localparam logic [1:0] M_LOAD = 2'd3;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ALL_ZERO = '0;

   state_t           state_reg;
   logic             dir_reg;
   logic [WIDTH-1:0] end_reg;

   // A step issued from the range edge in the run direction wraps the counter.
   logic             wrap_step;
   assign wrap_step = dir_reg ? (cnt_in == ALL_ZERO) : (cnt_in == ALL_ONES);

   // Controller FSM. All outputs are registered here.
   // Reset clears the mode at once, so the counter holds while reset is active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         dir_reg   <= 1'b0;
         end_reg   <= '0;
         m         <= M_HOLD;
         p         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         steps     <= '0;
         wrapped   <= 1'b0;
      end else begin
         // done is a single-cycle pulse. It is cleared on every edge unless it is set below.
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               m <= M_HOLD;
               if (start) begin
                  dir_reg   <= dir;
                  end_reg   <= end_val;
                  m         <= M_LOAD;
                  p         <= start_val;
                  steps     <= '0;
                  wrapped   <= 1'b0;
                  busy      <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  // steps and wrapped are kept so the host can see how far the run got.
                  m         <= M_HOLD;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else if (cnt_in == end_reg) begin
                  m         <= M_HOLD;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else if (pause) begin
                  m <= M_HOLD;
               end else begin
                  m     <= dir_reg ? M_DEC : M_INC;
                  steps <= steps + 1'b1;
                  if (wrap_step) begin
                     wrapped <= 1'b1;
                  end
               end
            end
            default: begin
               m         <= M_HOLD;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: bench for counter_seq_ctrl.
// A behavioural model of the counter updates on the falling edge and closes the loop.
// Each run is a row of the vector table. A row's expected results are queued
// when its start is driven, and they are popped when the run ends.
module tb_counter_seq_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             dir;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] cnt;
   logic [1:0]       m;
   logic [WIDTH-1:0] p;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   steps;
   logic             wrapped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] sv;
      logic [7:0] ev;
      logic       dir;
      int         pat;     // first edge index with pause high (0 = none)
      int         plen;    // number of paused edges
      int         aat;     // edge index at which abort is high (0 = none)
      int         rat;     // edge index at which a stray start is driven (0 = none)
      int         e_steps;
      int         e_wrap;
      int         e_done;
      int         e_lat;   // rising edges from the start sample to busy falling
   } vec_t;

   typedef struct {
      int steps;
      int wrap;
      int done;
      int lat;
      int fin_cnt;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];

   counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dir       (dir),
      .start_val (start_val),
      .end_val   (end_val),
      .pause     (pause),
      .abort     (abort),
      .cnt_in    (cnt),
      .m         (m),
      .p         (p),
      .busy      (busy),
      .done      (done),
      .steps     (steps),
      .wrapped   (wrapped)
   );

   always #5 clk = ~clk;

   // Counter model: the mode takes effect on the falling edge.
   initial cnt = 8'd0;
   always @(negedge clk) begin
      case (m)
         2'd1:    cnt <= cnt + 8'd1;
         2'd2:    cnt <= cnt - 8'd1;
         2'd3:    cnt <= p;
         default: cnt <= cnt;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t e;
      int   lat;
      bit   fin;
      int   step_m;
      e.steps   = v.e_steps;
      e.wrap    = v.e_wrap;
      e.done    = v.e_done;
      e.lat     = v.e_lat;
      e.fin_cnt = v.ev;
      sb.push_back(e);
      step_m    = v.dir ? 2 : 1;
      start_val = v.sv;
      end_val   = v.ev;
      dir       = v.dir;
      start     = 1'b1;
      tick();  // edge k0: start sampled
      start     = 1'b0;
      // Change the inputs after the sample to prove they were latched.
      start_val = 8'hA5;
      end_val   = 8'h5A;
      dir       = ~v.dir;
      chk("done_pulse_width", done, 0);
      chk("load_m", m, 3);
      chk("load_p", p, v.sv);
      chk("busy_on", busy, 1);
      chk("steps_clr", steps, 0);
      chk("wrapped_clr", wrapped, 0);
      fin = 1'b0;
      lat = 0;
      for (int i = 1; i <= 300 && !fin; i++) begin
         pause = (v.plen != 0 && i >= v.pat && i < v.pat + v.plen);
         abort = (v.aat != 0 && i == v.aat);
         if (v.rat != 0 && i == v.rat) begin
            start     = 1'b1;
            start_val = 8'd100;
            end_val   = 8'd200;
         end else begin
            start = 1'b0;
         end
         tick();
         if (busy) begin
            if (pause) chk("pause_m", m, 0);
            else       chk("step_m", m, step_m);
         end else begin
            fin = 1'b1;
            lat = i;
         end
      end
      pause = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      e = sb.pop_front();
      if (!fin) begin
         chk("run_timeout", 0, 1);
      end else begin
         chk("latency", lat, e.lat);
         chk("done", done, e.done);
         chk("steps", steps, e.steps);
         chk("wrapped", wrapped, e.wrap);
         chk("end_m", m, 0);
         if (e.done != 0) chk("final_cnt", cnt, e.fin_cnt);
      end
      $display("run %0d start=%0d end=%0d dir=%0d lat=%0d steps=%0d wrapped=%0d done=%0d",
               idx, v.sv, v.ev, v.dir, lat, steps, wrapped, done);
   endtask

   initial begin
      vec_t rv;
      int   cnt_save;
      rst       = 1'b1;
      start     = 1'b0;
      dir       = 1'b0;
      start_val = '0;
      end_val   = '0;
      pause     = 1'b0;
      abort     = 1'b0;

      //        sv   ev   dir pat plen aat rat steps wrap done lat
      vecs[0]  = '{8'd10,  8'd15,  1'b0, 0, 0, 0, 0,  5, 0, 1,  6};
      vecs[1]  = '{8'd2,   8'd254, 1'b1, 0, 0, 0, 0,  4, 1, 1,  5};
      vecs[2]  = '{8'd0,   8'd3,   1'b0, 2, 2, 0, 0,  3, 0, 1,  6};
      vecs[3]  = '{8'd0,   8'd9,   1'b0, 0, 0, 3, 0,  2, 0, 0,  3};
      vecs[4]  = '{8'd77,  8'd77,  1'b0, 0, 0, 0, 0,  0, 0, 1,  1};
      vecs[5]  = '{8'd250, 8'd4,   1'b0, 0, 0, 0, 0, 10, 1, 1, 11};
      vecs[6]  = '{8'd5,   8'd1,   1'b1, 0, 0, 0, 0,  4, 0, 1,  5};
      vecs[7]  = '{8'd0,   8'd255, 1'b1, 0, 0, 0, 0,  1, 1, 1,  2};
      vecs[8]  = '{8'd254, 8'd3,   1'b0, 0, 0, 4, 0,  3, 1, 0,  4};
      vecs[9]  = '{8'd20,  8'd25,  1'b0, 0, 0, 0, 2,  5, 0, 1,  6};
      vecs[10] = '{8'd255, 8'd0,   1'b0, 0, 0, 0, 0,  1, 1, 1,  2};

      tick();
      tick();
      chk("rst_m", m, 0);
      chk("rst_p", p, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_steps", steps, 0);
      chk("rst_wrapped", wrapped, 0);
      rst = 1'b0;
      tick();

      // Runs follow each other back to back: each start is driven in the cycle right after done.
      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end
      tick();
      chk("done_after_last", done, 0);

      // Assert reset asynchronously in the middle of a run, before the falling edge.
      start_val = 8'd0;
      end_val   = 8'd100;
      dir       = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("midrun_m", m, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_m", m, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_steps", steps, 0);
      chk("async_rst_wrapped", wrapped, 0);
      cnt_save = cnt;
      tick();
      tick();
      chk("rst_cnt_hold", cnt, 2);
      chk("rst_cnt_stable", cnt, cnt_save);
      rst = 1'b0;
      tick();
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_m", m, 0);
      $display("reset mid-run cnt=%0d m=%0d busy=%0d", cnt, m, busy);

      rv = '{8'd77, 8'd80, 1'b0, 0, 0, 0, 0, 3, 0, 1, 4};
      run_vec(11, rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the 8-bit loadable up/down counter (modes hold/inc/dec/load).
- Accepts a one-cycle run command (start value, end value, direction) and loads the counter.
- Steps the counter toward the end value, with pause and abort.
- Reports completion, the number of steps issued, and whether the count wrapped.
- Sits between the command/host logic and the counter's mode and parallel-load inputs.

## Interface
- WIDTH, 8, data width of counter value, start and end values.
- clk  in  1  clock; controller registers update on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run command, sampled only in IDLE.
- dir  in  1  0 = count up (mode 1), 1 = count down (mode 2); latched on start.
- start_val  in  WIDTH  value loaded into counter; latched on start.
- end_val  in  WIDTH  terminal value; latched on start.
- pause  in  1  level; holds counter while high during RUN.
- abort  in  1  level; terminates a run without done.
- cnt_in  in  WIDTH  counter output (fout) fed back.
- m  out  2  counter mode: 0 hold, 1 inc, 2 dec, 3 load; registered.
- p  out  WIDTH  counter parallel-load value; registered.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse on normal completion.
- steps  out  WIDTH+1  inc/dec commands issued in the current or last run.
- wrapped  out  1  set if the run crossed the top or bottom of the range; held until next start.

## Operation
- States: IDLE and RUN. All outputs are registered.
- Reset values (asynchronous, immediate):
  - state = IDLE, m = 0, p = 0, busy = 0, done = 0, steps = 0, wrapped = 0.
- IDLE:
  - Default: m = 0, done = 0.
  - On start = 1:
    - Latch dir, end_val.
    - m <= 3, p <= start_val.
    - steps <= 0, wrapped <= 0.
    - busy <= 1, state <= RUN.
- RUN: each rising edge evaluates in priority order.
  1. abort = 1: m <= 0, busy <= 0, state <= IDLE. No done; steps and wrapped keep their values.
  2. cnt_in == latched end: m <= 0, done <= 1, busy <= 0, state <= IDLE.
  3. pause = 1: m <= 0; stay in RUN.
  4. Otherwise:
     - m <= (dir ? 2 : 1), steps <= steps + 1.
     - wrapped <= 1 if (up and cnt_in == all-ones) or (down and cnt_in == 0).
- start in RUN is ignored. p is only meaningful while m = 3 and keeps its last value otherwise.
- Counter arithmetic wraps modulo 2^WIDTH, so end is always reached.
  - Up run issues (end − start) mod 2^WIDTH steps; down run issues (start − end) mod 2^WIDTH.
  - Steps never exceed 2^WIDTH − 1, so the WIDTH+1-bit steps field never overflows.
- done is high for exactly one cycle; the next cycle is IDLE, so back-to-back start is accepted there.

## Timing
- Counter registers update on the falling clk edge. A mode driven at rising edge k takes effect at the following falling edge. cnt_in sampled at rising edge k+1 reflects it.
- Start sampled at edge k0 → load at the falling edge after k0 → cnt_in = start_val at edge k1 = k0+1.
- For N steps with no pause, equality is detected and done/busy-fall are registered at edge k1+N. Each paused cycle adds one cycle.
- start_val == end_val: done at k1, steps = 0, counter never steps.
- Asynchronous reset mid-run: m = 0 immediately (counter holds); run state is discarded.

## Test plan
- Reset: assert rst mid-RUN → m = 0, busy = 0, done = 0, steps = 0, wrapped = 0 without a clock edge; counter holds.
- Up run: start_val = 10, end_val = 15, dir = 0 → m = 3 for one cycle, then m = 1 for 5 cycles. done pulses 6 rising edges after start sample; steps = 5, wrapped = 0, cnt_in = 15 held.
- Down wrap: start_val = 2, end_val = 254, dir = 1 → 4 dec steps (2, 1, 0, 255, 254), wrapped = 1, steps = 4, single done pulse.
- Pause: up run 0 → 3 with pause high for 2 cycles mid-run → m = 0 during pause, done delayed exactly 2 cycles, steps = 3.
- Abort and zero-length: abort after 2 steps of 0 → 9 → busy falls, no done, steps = 2, m = 0. Then start with start_val = end_val = 77 → done at k1, steps = 0.
- Start while busy ignored; start in the cycle after done is accepted and resets steps/wrapped.
